// File: rtl/flash_arb_pkg.sv
// Shared types and pin constants for the QSPI flash bus arbiter.
// Owner encoding doubles as the oOWNER output value.
package flash_arb_pkg;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_S    = 2'd1,
    OWNER_Q    = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_S = 2'd1,
    ST_OWN_Q = 2'd2,
    ST_GUARD = 2'd3
  } state_e;

  // WP# and HOLD# (IO2/IO3) are driven inactive-high whenever nobody owns the bus.
  localparam logic [3:0] DOUT_IDLE = 4'b1100;
  localparam logic [3:0] DOE_IDLE  = 4'b1100;
  localparam logic [3:0] DOE_S     = 4'b1101;

  // Round-robin tie-break: the previous owner yields; with no history use the priority.
  function automatic owner_e tieWinner(input owner_e lastOwner, input logic prioQ);
    case (lastOwner)
      OWNER_S: tieWinner = OWNER_Q;
      OWNER_Q: tieWinner = OWNER_S;
      default: tieWinner = prioQ ? OWNER_Q : OWNER_S;
    endcase
  endfunction

endpackage

// File: rtl/flash_arb_pinmux.sv
// Combinational owner-select mux between the two masters and the flash pads.
// A non-owner never reaches the pins and sees zeros on its returned data.
module flash_arb_pinmux
  import flash_arb_pkg::*;
(
  input  owner_e      owner,
  input  logic        sCsN,
  input  logic        sSck,
  input  logic        sMosi,
  output logic        sMiso,
  input  logic        qNcs,
  input  logic        qSck,
  input  logic [3:0]  qDout,
  input  logic [3:0]  qDoe,
  output logic [3:0]  qDin,
  output logic        flashCsN,
  output logic        flashSck,
  output logic [3:0]  flashDout,
  output logic [3:0]  flashDoe,
  input  logic [3:0]  flashDin
);

  logic selS;
  logic selQ;

  assign selS = (owner == OWNER_S);
  assign selQ = (owner == OWNER_Q);

  always_comb begin
    flashCsN  = 1'b1;
    flashSck  = 1'b0;
    flashDout = DOUT_IDLE;
    flashDoe  = DOE_IDLE;
    if (selS) begin
      flashCsN  = sCsN;
      flashSck  = sSck;
      flashDout = {3'b110, sMosi};
      flashDoe  = DOE_S;
    end else if (selQ) begin
      flashCsN  = qNcs;
      flashSck  = qSck;
      flashDout = qDout;
      flashDoe  = qDoe;
    end
  end

  assign sMiso = selS & flashDin[1];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : gQDin
      assign qDin[gi] = selQ & flashDin[gi];
    end
  endgenerate

endmodule

// File: rtl/flash_bus_arbiter.sv
// Request/grant arbiter sharing one QSPI flash between the SPI master (S) and
// the XIP controller (Q), with CS-high guard time and optional hold revocation.
module flash_bus_arbiter
  import flash_arb_pkg::*;
#(
  parameter int GUARD_CYCLES = 4,
  parameter int MAX_HOLD     = 0,
  parameter int PRIO_Q       = 1
) (
  input  logic        iCLK,
  input  logic        iRESET,
  input  logic        iS_REQ,
  output logic        oS_GNT,
  input  logic        iS_CS_N,
  input  logic        iS_SCK,
  input  logic        iS_MOSI,
  output logic        oS_MISO,
  input  logic        iQ_REQ,
  output logic        oQ_GNT,
  input  logic        iQ_NCS,
  input  logic        iQ_SCK,
  input  logic [3:0]  iQ_DOUT,
  input  logic [3:0]  iQ_DOE,
  output logic [3:0]  oQ_DIN,
  output logic        oFLASH_CS_N,
  output logic        oFLASH_SCK,
  output logic [3:0]  oFLASH_DOUT,
  output logic [3:0]  oFLASH_DOE,
  input  logic [3:0]  iFLASH_DIN,
  output logic [1:0]  oOWNER,
  output logic        oVIOL
);

  localparam logic [7:0]  GUARD_LOAD = 8'(GUARD_CYCLES - 1);
  localparam logic [15:0] HOLD_LIMIT = 16'(MAX_HOLD);
  localparam logic        REVOKE_EN  = (MAX_HOLD != 0);

  state_e        state;
  owner_e        ownerSel;
  owner_e        lastOwner;
  owner_e        idleWinner;
  logic [15:0]   holdCnt;
  logic [7:0]    guardCnt;
  logic          holdExpired;
  logic          sRelease;
  logic          qRelease;

  assign holdExpired = REVOKE_EN && (holdCnt >= HOLD_LIMIT);

  // Release is only ever allowed with the owner's CS high, so no transaction is cut.
  assign sRelease = iS_CS_N && (!iS_REQ || (holdExpired && iQ_REQ));
  assign qRelease = iQ_NCS  && (!iQ_REQ || (holdExpired && iS_REQ));

  assign idleWinner = (iS_REQ && iQ_REQ) ? tieWinner(lastOwner, PRIO_Q != 0)
                    : (iQ_REQ ? OWNER_Q : OWNER_S);

  assign oOWNER = ownerSel;

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state     <= ST_IDLE;
      ownerSel  <= OWNER_NONE;
      lastOwner <= OWNER_NONE;
      oS_GNT    <= 1'b0;
      oQ_GNT    <= 1'b0;
      oVIOL     <= 1'b0;
      holdCnt   <= '0;
      guardCnt  <= '0;
    end else begin
      oVIOL <= (!oS_GNT && !iS_CS_N) || (!oQ_GNT && !iQ_NCS);
      case (state)
        ST_IDLE: begin
          if (iS_REQ || iQ_REQ) begin
            holdCnt  <= '0;
            ownerSel <= idleWinner;
            oS_GNT   <= (idleWinner == OWNER_S);
            oQ_GNT   <= (idleWinner == OWNER_Q);
            state    <= (idleWinner == OWNER_S) ? ST_OWN_S : ST_OWN_Q;
          end
        end
        ST_OWN_S: begin
          if (sRelease) begin
            state     <= ST_GUARD;
            guardCnt  <= GUARD_LOAD;
            oS_GNT    <= 1'b0;
            ownerSel  <= OWNER_NONE;
            lastOwner <= OWNER_S;
          end else if (holdCnt != 16'hFFFF) begin
            holdCnt <= holdCnt + 16'd1;
          end
        end
        ST_OWN_Q: begin
          if (qRelease) begin
            state     <= ST_GUARD;
            guardCnt  <= GUARD_LOAD;
            oQ_GNT    <= 1'b0;
            ownerSel  <= OWNER_NONE;
            lastOwner <= OWNER_Q;
          end else if (holdCnt != 16'hFFFF) begin
            holdCnt <= holdCnt + 16'd1;
          end
        end
        default: begin
          if (guardCnt == 8'd0) state <= ST_IDLE;
          else                  guardCnt <= guardCnt - 8'd1;
        end
      endcase
    end
  end

  flash_arb_pinmux uPinmux (
    .owner     (ownerSel),
    .sCsN      (iS_CS_N),
    .sSck      (iS_SCK),
    .sMosi     (iS_MOSI),
    .sMiso     (oS_MISO),
    .qNcs      (iQ_NCS),
    .qSck      (iQ_SCK),
    .qDout     (iQ_DOUT),
    .qDoe      (iQ_DOE),
    .qDin      (oQ_DIN),
    .flashCsN  (oFLASH_CS_N),
    .flashSck  (oFLASH_SCK),
    .flashDout (oFLASH_DOUT),
    .flashDoe  (oFLASH_DOE),
    .flashDin  (iFLASH_DIN)
  );

endmodule

// File: tb/tb_flash_bus_arbiter.sv
// Directed bench for flash_bus_arbiter (GUARD_CYCLES=4, MAX_HOLD=8, PRIO_Q=1).
// Outputs are sampled 1 time unit after the rising edge; inputs change there too.
module tb_flash_bus_arbiter;

  logic       iCLK = 1'b0;
  logic       iRESET;
  logic       iS_REQ, iS_CS_N, iS_SCK, iS_MOSI;
  logic       iQ_REQ, iQ_NCS, iQ_SCK;
  logic [3:0] iQ_DOUT, iQ_DOE, iFLASH_DIN;
  logic       oS_GNT, oS_MISO, oQ_GNT, oFLASH_CS_N, oFLASH_SCK, oVIOL;
  logic [3:0] oQ_DIN, oFLASH_DOUT, oFLASH_DOE;
  logic [1:0] oOWNER;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 iCLK = ~iCLK;

  flash_bus_arbiter #(.GUARD_CYCLES(4), .MAX_HOLD(8), .PRIO_Q(1)) dut (
    .iCLK(iCLK), .iRESET(iRESET),
    .iS_REQ(iS_REQ), .oS_GNT(oS_GNT), .iS_CS_N(iS_CS_N), .iS_SCK(iS_SCK),
    .iS_MOSI(iS_MOSI), .oS_MISO(oS_MISO),
    .iQ_REQ(iQ_REQ), .oQ_GNT(oQ_GNT), .iQ_NCS(iQ_NCS), .iQ_SCK(iQ_SCK),
    .iQ_DOUT(iQ_DOUT), .iQ_DOE(iQ_DOE), .oQ_DIN(oQ_DIN),
    .oFLASH_CS_N(oFLASH_CS_N), .oFLASH_SCK(oFLASH_SCK),
    .oFLASH_DOUT(oFLASH_DOUT), .oFLASH_DOE(oFLASH_DOE), .iFLASH_DIN(iFLASH_DIN),
    .oOWNER(oOWNER), .oVIOL(oVIOL)
  );

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    testsRun++;
    assert (obs === expv) else begin
      testsFailed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chkIdlePins(input string tag);
    chk({tag, " cs_n"}, {7'd0, oFLASH_CS_N}, 8'h01);
    chk({tag, " doe"},  {4'd0, oFLASH_DOE},  8'h0C);
    chk({tag, " dout"}, {4'd0, oFLASH_DOUT}, 8'h0C);
    chk({tag, " owner"}, {6'd0, oOWNER}, 8'h00);
    chk({tag, " gnts"}, {6'd0, oS_GNT, oQ_GNT}, 8'h00);
  endtask

  initial begin
    int  n;
    logic csHigh;

    iRESET = 1'b1;
    iS_REQ = 0; iS_CS_N = 1; iS_SCK = 0; iS_MOSI = 0;
    iQ_REQ = 0; iQ_NCS = 1; iQ_SCK = 0; iQ_DOUT = 4'h0; iQ_DOE = 4'h0;
    iFLASH_DIN = 4'h0;

    // Reset state
    tick(); tick();
    chkIdlePins("reset");
    chk("reset sck",  {7'd0, oFLASH_SCK}, 8'h00);
    chk("reset viol", {7'd0, oVIOL}, 8'h00);
    iRESET = 1'b0;
    tick();

    // S only: grant one cycle after request, S pin mapping
    iS_REQ = 1;
    tick();
    chk("s_only gnt", {6'd0, oS_GNT, oQ_GNT}, 8'h02);
    chk("s_only owner", {6'd0, oOWNER}, 8'h01);
    iS_MOSI = 1; iFLASH_DIN = 4'b0010; iS_CS_N = 0; iS_SCK = 1;
    #1;
    chk("s_only dout", {4'd0, oFLASH_DOUT}, 8'h0D);
    chk("s_only doe",  {4'd0, oFLASH_DOE},  8'h0D);
    chk("s_only miso", {7'd0, oS_MISO}, 8'h01);
    chk("s_only qdin", {4'd0, oQ_DIN}, 8'h00);
    chk("s_only cs_sck", {6'd0, oFLASH_CS_N, oFLASH_SCK}, 8'h01);
    iS_REQ = 0; iS_CS_N = 1; iS_SCK = 0; iS_MOSI = 0;
    tick();
    chkIdlePins("s_release");
    for (int i = 0; i < 4; i++) tick();

    // Tie from reset: PRIO_Q wins
    iRESET = 1'b1;
    #2;
    iRESET = 1'b0;
    iS_REQ = 1; iQ_REQ = 1;
    tick();
    chk("tie gnt", {6'd0, oS_GNT, oQ_GNT}, 8'h01);
    chk("tie owner", {6'd0, oOWNER}, 8'h02);
    iQ_REQ = 0;
    tick();
    chk("q_release gnt", {7'd0, oQ_GNT}, 8'h00);
    n = 0; csHigh = 1'b1;
    while (!oS_GNT && n < 20) begin
      if (oFLASH_CS_N !== 1'b1) csHigh = 1'b0;
      n++;
      tick();
    end
    chk("guard gap", 8'(n), 8'd5);
    chk("guard cs high", {7'd0, csHigh}, 8'h01);
    chk("guard s gnt", {6'd0, oS_GNT, oQ_GNT}, 8'h02);

    // Round robin: S was last owner, both request during guard
    iS_REQ = 0;
    tick();
    iS_REQ = 1; iQ_REQ = 1;
    n = 0;
    while (!oS_GNT && !oQ_GNT && n < 20) begin n++; tick(); end
    chk("rr gnt", {6'd0, oS_GNT, oQ_GNT}, 8'h01);

    // Late release: Q drops REQ while NCS low, grant held
    iS_REQ = 0; iQ_NCS = 0; iQ_REQ = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("late hold gnt", {7'd0, oQ_GNT}, 8'h01);
    end
    chk("late cs pin", {7'd0, oFLASH_CS_N}, 8'h00);
    iQ_NCS = 1;
    #1;
    chk("late gnt same cycle", {7'd0, oQ_GNT}, 8'h01);
    tick();
    chk("late release", {7'd0, oQ_GNT}, 8'h00);
    for (int i = 0; i < 4; i++) tick();

    // MAX_HOLD revocation
    iQ_REQ = 1;
    tick();
    chk("mh q gnt", {7'd0, oQ_GNT}, 8'h01);
    iQ_NCS = 0;
    for (int i = 0; i < 3; i++) tick();
    iS_REQ = 1;
    for (int i = 0; i < 9; i++) tick();
    chk("mh held at 12", {7'd0, oQ_GNT}, 8'h01);
    iQ_NCS = 1;
    tick();
    chk("mh revoked", {6'd0, oS_GNT, oQ_GNT}, 8'h00);
    chk("mh owner", {6'd0, oOWNER}, 8'h00);
    iQ_NCS = 0;
    tick();
    chk("mh late viol", {7'd0, oVIOL}, 8'h01);
    chk("mh late cs pin", {7'd0, oFLASH_CS_N}, 8'h01);
    iQ_NCS = 1;
    tick();
    chk("mh viol clear", {7'd0, oVIOL}, 8'h00);
    n = 0;
    while (!oS_GNT && !oQ_GNT && n < 20) begin n++; tick(); end
    chk("mh s granted", {6'd0, oS_GNT, oQ_GNT}, 8'h02);
    iQ_REQ = 0; iS_REQ = 0;
    tick();
    for (int i = 0; i < 4; i++) tick();

    // Violation: S without grant lowers CS
    iS_CS_N = 0;
    #1;
    chk("viol cs pin", {7'd0, oFLASH_CS_N}, 8'h01);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("viol pulse", {7'd0, oVIOL}, 8'h01);
    end
    iS_CS_N = 1;
    tick();
    chk("viol end", {7'd0, oVIOL}, 8'h00);

    // Reset in the middle of a Q read
    iQ_REQ = 1;
    tick();
    iQ_NCS = 0; iQ_DOE = 4'hF; iQ_DOUT = 4'hA; iFLASH_DIN = 4'h5;
    #1;
    chk("rst pre cs", {7'd0, oFLASH_CS_N}, 8'h00);
    chk("rst pre qdin", {4'd0, oQ_DIN}, 8'h05);
    iRESET = 1'b1;
    #1;
    chkIdlePins("rst async");
    iS_REQ = 1; iQ_NCS = 1;
    tick();
    iRESET = 1'b0;
    tick();
    chk("rst prio gnt", {6'd0, oS_GNT, oQ_GNT}, 8'h01);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/flash_bus_arbiter.md
Name: flash_bus_arbiter

Overview:
- Shares the single QSPI flash pin set between two masters: the single-bit SPI master (requester S) and the QSPI XIP/config controller (requester Q).
- Arbitrates exclusive ownership with a request/grant handshake and never switches owner while chip select is low.
- Enforces a minimum CS-high guard time between owners and can bound ownership when the other master is waiting.
- Sits between the SoC masters and the top-level flash pad tristates; it replaces ad-hoc combinational pin sharing.

Parameters:
- GUARD_CYCLES, 4: iCLK cycles the flash is held deselected after an owner releases, before any new grant (covers flash tSHSL). Legal range 1..255.
- MAX_HOLD, 0: hold cycles after which the owner is revoked when the other requester is waiting and owner CS is high. 0 disables revocation. Legal range 0..65535.
- PRIO_Q, 1: tie-break when both request from IDLE with no prior owner. 1 = Q wins, 0 = S wins.

Ports:
- iCLK  in  1  system clock; all other inputs are synchronous to it
- iRESET  in  1  asynchronous, active-high reset
- iS_REQ  in  1  S requests the bus
- oS_GNT  out  1  S owns the bus
- iS_CS_N  in  1  S chip select
- iS_SCK  in  1  S serial clock
- iS_MOSI  in  1  S data out
- oS_MISO  out  1  flash IO1 to S; 0 when S is not owner
- iQ_REQ  in  1  Q requests the bus
- oQ_GNT  out  1  Q owns the bus
- iQ_NCS  in  1  Q chip select
- iQ_SCK  in  1  Q gated serial clock
- iQ_DOUT  in  4  Q IO data out
- iQ_DOE  in  4  Q IO output enables
- oQ_DIN  out  4  flash IO[3:0] to Q; 0 when Q is not owner
- oFLASH_CS_N  out  1  flash chip select pin
- oFLASH_SCK  out  1  flash clock pin
- oFLASH_DOUT  out  4  IO[3:0] drive value
- oFLASH_DOE  out  4  IO[3:0] output enables (top-level builds the tristates)
- iFLASH_DIN  in  4  IO[3:0] pad inputs
- oOWNER  out  2  0 = none, 1 = S, 2 = Q
- oVIOL  out  1  one-cycle pulse: a non-owner drove CS low

Behaviour:
- Reset (asynchronous) forces:
  - state IDLE; both grants 0; oOWNER 0; oVIOL 0; counters 0; last-owner = none.
  - pins idle: CS_N 1, SCK 0, DOUT 4'b1100, DOE 4'b1100 (WP/HOLD driven inactive high).
- State machine IDLE, OWN_S, OWN_Q, GUARD; state and grants are registered.
- IDLE:
  - single request: grant that requester the next cycle (GNT 1 cycle after REQ).
  - both request: grant the requester that was not the last owner; with no last owner, use PRIO_Q.
- OWN_x:
  - pins follow owner combinationally from the registered select.
  - S owner: CS_N = iS_CS_N, SCK = iS_SCK, DOUT = {1,1,0,iS_MOSI}, DOE = 4'b1101; oS_MISO = iFLASH_DIN[1].
  - Q owner: CS_N = iQ_NCS, SCK = iQ_SCK, DOUT = iQ_DOUT, DOE = iQ_DOE; oQ_DIN = iFLASH_DIN.
  - hold counter increments each cycle in OWN_x and saturates.
- Release (OWN_x -> GUARD, grant drops the same edge):
  - voluntary: owner REQ = 0 and owner CS_N = 1.
  - REQ dropped while CS_N = 0: stay in OWN_x until CS_N = 1, so no mid-transaction cut.
  - revocation: MAX_HOLD ≠ 0, hold counter ≥ MAX_HOLD, other REQ = 1, and owner CS_N = 1.
  - every release sets last-owner = x.
- GUARD:
  - pins idle; guard counter loads GUARD_CYCLES−1 on entry and counts down.
  - at 0 go to IDLE; IDLE grants the same cycle it sees a request, so the pin-deselect gap is ≥ GUARD_CYCLES+1.
  - requests seen during GUARD are held, not dropped.
- Violation: in any cycle where a requester without grant has CS low, pulse oVIOL. That CS never reaches the pin. Includes the cycle after revocation if the old owner lowers CS late.
- Simultaneous release and other request: go to GUARD first; no direct owner-to-owner hand-off.
- Reset mid-transaction: pins go idle immediately; masters must restart.

Decomposition:
- Package flash_arb_pkg:
  - owner encoding (NONE/S/Q)
  - state enum
  - pin idle constants (DOUT_IDLE = 4'b1100, DOE_IDLE = 4'b1100, DOE_S = 4'b1101)
- Sub-module flash_arb_pinmux: purely combinational owner-select mux for pins and the returned data; the FSM and counters stay in the top module.

Test Plan:
- S only: iS_REQ = 1 at cycle 0 -> oS_GNT = 1 and oOWNER = 1 at cycle 1. Drive iS_MOSI = 1 -> oFLASH_DOUT = 4'b1101, DOE = 4'b1101. iFLASH_DIN = 4'b0010 -> oS_MISO = 1 and oQ_DIN = 0.
- Tie from reset with PRIO_Q = 1: both REQ at cycle 0 -> Q granted at cycle 1. Q releases -> ≥5 cycles of CS_N = 1 (GUARD_CYCLES = 4) -> S granted. Both request again -> Q granted (round-robin).
- Late release: Q drops REQ with iQ_NCS = 0 for 10 cycles -> grant held all 10 cycles. NCS rises -> oQ_GNT = 0 on the next edge.
- MAX_HOLD = 8: Q owns, S requests at hold count 3, Q NCS low until count 12 -> revoked only at the first CS-high cycle after count 12, then S granted after GUARD.
- Violation: S without grant drives iS_CS_N = 0 -> oVIOL pulses 1 cycle per cycle CS is low, and oFLASH_CS_N stays 1.
- iRESET asserted mid Q read (NCS low) -> asynchronously CS_N = 1, DOE = 4'b1100, oOWNER = 0, no grants. Release reset with both REQ = 1 -> PRIO_Q winner granted 1 cycle later.
